// File: rtl/lsu_if.sv
// ============================================================================
// Module  : lsu_if
// Brief   : Bundles the execute-side request, memory bus and writeback signals
//           of the load/store unit.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface lsu_if #(
    parameter int DATA_WIDTH = 32
);
    // Execute-side request
    logic                  req_valid_i;
    logic                  req_ready_o;
    logic                  we_i;
    logic [1:0]            size_i;
    logic                  sign_ext_i;
    logic [DATA_WIDTH-1:0] addr_i;
    logic [DATA_WIDTH-1:0] wdata_i;
    logic [4:0]            rd_i;

    // Memory bus
    logic                  data_req_o;
    logic                  data_gnt_i;
    logic [DATA_WIDTH-1:0] data_addr_o;
    logic                  data_we_o;
    logic [3:0]            data_be_o;
    logic [DATA_WIDTH-1:0] data_wdata_o;
    logic                  data_rvalid_i;
    logic [DATA_WIDTH-1:0] data_rdata_i;

    // Writeback and error
    logic                  wb_valid_o;
    logic [4:0]            wb_rd_o;
    logic [DATA_WIDTH-1:0] wb_data_o;
    logic                  err_o;

    // The LSU itself
    modport slave (
        input  req_valid_i, we_i, size_i, sign_ext_i, addr_i, wdata_i, rd_i,
        input  data_gnt_i, data_rvalid_i, data_rdata_i,
        output req_ready_o, data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o,
        output wb_valid_o, wb_rd_o, wb_data_o, err_o
    );

    // Execute stage plus memory system surrounding the LSU
    modport master (
        output req_valid_i, we_i, size_i, sign_ext_i, addr_i, wdata_i, rd_i,
        output data_gnt_i, data_rvalid_i, data_rdata_i,
        input  req_ready_o, data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o,
        input  wb_valid_o, wb_rd_o, wb_data_o, err_o
    );
endinterface

`default_nettype wire

// File: rtl/lsu.sv
// ============================================================================
// Module  : lsu
// Brief   : Single-outstanding load/store unit with byte-lane placement and
//           load extraction/extension.
// Revision: 1.0
// ============================================================================
`default_nettype none

module lsu #(
    parameter int DATA_WIDTH = 32
) (
    input  logic  clk_i,
    input  logic  rst_i,
    lsu_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t                state;
    state_t                state_next;
    logic                  req_ready;
    logic                  data_req;
    logic                  resp_done;
    logic                  accept;
    logic                  misaligned;

    logic [3:0]            be_new;
    logic [DATA_WIDTH-1:0] wdata_new;
    logic [DATA_WIDTH-1:0] load_shift;
    logic [DATA_WIDTH-1:0] load_data;

    logic [DATA_WIDTH-1:0] mem_addr;
    logic                  mem_we;
    logic [3:0]            mem_be;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [1:0]            ld_size;
    logic                  ld_sext;
    logic [1:0]            ld_off;
    logic [4:0]            ld_rd;
    logic                  wb_valid;
    logic [4:0]            wb_rd;
    logic [DATA_WIDTH-1:0] wb_data;
    logic                  err;

    assign accept = bus.req_valid_i && req_ready;

    always_comb begin
        case (bus.size_i)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = bus.addr_i[0];
            2'b10:   misaligned = |bus.addr_i[1:0];
            default: misaligned = 1'b1;
        endcase
    end

    // Lane placement computed from the raw request so it can be registered at accept.
    always_comb begin
        be_new    = 4'b1111;
        wdata_new = bus.wdata_i;
        case (bus.size_i)
            2'b00: begin
                be_new    = 4'b0001 << bus.addr_i[1:0];
                wdata_new = {(DATA_WIDTH/8){bus.wdata_i[7:0]}};
            end
            2'b01: begin
                be_new    = 4'b0011 << bus.addr_i[1:0];
                wdata_new = {(DATA_WIDTH/16){bus.wdata_i[15:0]}};
            end
            default: ;
        endcase
    end

    assign load_shift = bus.data_rdata_i >> {ld_off, 3'b000};

    always_comb begin
        case (ld_size)
            2'b00:   load_data = {{(DATA_WIDTH-8){ld_sext & load_shift[7]}}, load_shift[7:0]};
            2'b01:   load_data = {{(DATA_WIDTH-16){ld_sext & load_shift[15]}}, load_shift[15:0]};
            default: load_data = load_shift;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        data_req   = 1'b0;
        resp_done  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (bus.req_valid_i && !misaligned) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                data_req = 1'b1;
                if (bus.data_gnt_i) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (bus.data_rvalid_i) begin
                    resp_done  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_be    <= 4'b0000;
            mem_wdata <= '0;
            ld_size   <= 2'b00;
            ld_sext   <= 1'b0;
            ld_off    <= 2'b00;
            ld_rd     <= 5'd0;
            wb_valid  <= 1'b0;
            wb_rd     <= 5'd0;
            wb_data   <= '0;
            err       <= 1'b0;
        end else begin
            err      <= accept && misaligned;
            wb_valid <= 1'b0;
            if (accept && !misaligned) begin
                mem_addr  <= {bus.addr_i[DATA_WIDTH-1:2], 2'b00};
                mem_we    <= bus.we_i;
                mem_be    <= be_new;
                mem_wdata <= wdata_new;
                ld_size   <= bus.size_i;
                ld_sext   <= bus.sign_ext_i;
                ld_off    <= bus.addr_i[1:0];
                ld_rd     <= bus.rd_i;
            end
            // Stores complete silently; only loads produce a writeback.
            if (resp_done && !mem_we) begin
                wb_valid <= 1'b1;
                wb_rd    <= ld_rd;
                wb_data  <= load_data;
            end
        end
    end

    assign bus.req_ready_o  = req_ready;
    assign bus.data_req_o   = data_req;
    assign bus.data_addr_o  = mem_addr;
    assign bus.data_we_o    = mem_we;
    assign bus.data_be_o    = mem_be;
    assign bus.data_wdata_o = mem_wdata;
    assign bus.wb_valid_o   = wb_valid;
    assign bus.wb_rd_o      = wb_rd;
    assign bus.wb_data_o    = wb_data;
    assign bus.err_o        = err;

endmodule

`default_nettype wire

// File: tb/tb_lsu.sv
// ============================================================================
// Module  : tb_lsu
// Brief   : Randomized self-checking bench for lsu with a transaction-level model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_lsu;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst;

    lsu_if #(.DATA_WIDTH(DW)) bus ();

    lsu #(.DATA_WIDTH(DW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    // Memory responder knobs: negative means random.
    int          gnt_cfg = -1;
    int          rv_cfg  = -1;
    bit          spur    = 1'b0;
    bit          rfix_en = 1'b0;
    logic [31:0] rfix    = 32'h0;
    bit          model_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit illegal(input logic [1:0] sz, input logic [31:0] a);
        return (sz == 2'd3) || ((a % nbytes(sz)) != 0);
    endfunction

    function automatic logic [3:0] exp_be(input logic [1:0] sz, input logic [31:0] a);
        return 4'(((1 << nbytes(sz)) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [1:0] sz, input logic [31:0] w);
        if (sz == 2'd0) return (w & 32'hFF) * 32'h0101_0101;
        if (sz == 2'd1) return (w & 32'hFFFF) * 32'h0001_0001;
        return w;
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] rdata, input logic [1:0] off,
                                            input logic [1:0] sz, input bit sx);
        int          nb;
        logic [31:0] mask;
        logic [31:0] v;
        nb   = nbytes(sz);
        mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nb)) - 32'h1);
        v    = (rdata >> (8 * off)) & mask;
        if (sx && nb < 4 && ((v >> (8 * nb - 1)) & 32'h1) != 0) v = v | ~mask;
        return v;
    endfunction

    // Transaction-level reference: one op in flight, tracked as busy/granted.
    initial begin
        bit          m_busy, m_granted, m_err_next, m_wb_next, m_after_rst, m_we, m_sext;
        logic [31:0] m_addr, m_wdata, m_wb_data;
        logic [3:0]  m_be;
        logic [1:0]  m_size, m_off;
        logic [4:0]  m_rd, m_wb_rd;
        m_busy = 0; m_granted = 0; m_err_next = 0; m_wb_next = 0; m_after_rst = 1;
        m_we = 0; m_sext = 0; m_addr = 0; m_wdata = 0; m_wb_data = 0; m_be = 0;
        m_size = 0; m_off = 0; m_rd = 0; m_wb_rd = 0;
        forever begin
            @(negedge clk);
            if (model_on) begin
                chk("req_ready", bus.req_ready_o, !m_busy);
                chk("data_req", bus.data_req_o, m_busy && !m_granted);
                if (m_busy && !m_granted) begin
                    chk("data_addr", bus.data_addr_o, m_addr);
                    chk("data_be", bus.data_be_o, m_be);
                    chk("data_we", bus.data_we_o, m_we);
                    chk("data_wdata", bus.data_wdata_o, m_wdata);
                end
                chk("err", bus.err_o, m_err_next);
                chk("wb_valid", bus.wb_valid_o, m_wb_next);
                chk("wb_data", bus.wb_data_o, m_wb_data);
                chk("wb_rd", bus.wb_rd_o, m_wb_rd);
                if (m_after_rst) begin
                    chk("rst_data_addr", bus.data_addr_o, 32'h0);
                    chk("rst_data_be", bus.data_be_o, 32'h0);
                    chk("rst_data_we", bus.data_we_o, 32'h0);
                    chk("rst_data_wdata", bus.data_wdata_o, 32'h0);
                end
                m_err_next = 0; m_wb_next = 0; m_after_rst = 0;
                if (rst) begin
                    m_busy = 0; m_granted = 0; m_wb_data = 0; m_wb_rd = 0; m_after_rst = 1;
                end else if (!m_busy) begin
                    if (bus.req_valid_i) begin
                        if (illegal(bus.size_i, bus.addr_i)) begin
                            m_err_next = 1;
                        end else begin
                            m_busy    = 1;
                            m_granted = 0;
                            m_we      = bus.we_i;
                            m_size    = bus.size_i;
                            m_sext    = bus.sign_ext_i;
                            m_off     = bus.addr_i[1:0];
                            m_rd      = bus.rd_i;
                            m_addr    = bus.addr_i & ~32'h3;
                            m_be      = exp_be(bus.size_i, bus.addr_i);
                            m_wdata   = exp_wdata(bus.size_i, bus.wdata_i);
                        end
                    end
                end else if (!m_granted) begin
                    if (bus.data_gnt_i) m_granted = 1;
                end else if (bus.data_rvalid_i) begin
                    m_busy = 0;
                    if (!m_we) begin
                        m_wb_next = 1;
                        m_wb_data = exp_load(bus.data_rdata_i, m_off, m_size, m_sext);
                        m_wb_rd   = m_rd;
                    end
                end
            end
        end
    end

    // Memory responder.
    initial begin
        bit req_n, gnt_n, rv_n, outst;
        int gwait, rwait;
        outst = 0; gwait = -1; rwait = 0;
        bus.data_gnt_i = 1'b0; bus.data_rvalid_i = 1'b0; bus.data_rdata_i = 32'h0;
        forever begin
            @(negedge clk);
            req_n = bus.data_req_o; gnt_n = bus.data_gnt_i; rv_n = bus.data_rvalid_i;
            @(posedge clk); #1;
            if (outst && rv_n) outst = 0;
            if (req_n && gnt_n) begin
                outst = 1;
                rwait = (rv_cfg < 0) ? int'($urandom_range(0, 3)) : rv_cfg;
            end
            if (bus.data_req_o) begin
                if (gwait < 0) gwait = (gnt_cfg < 0) ? int'($urandom_range(0, 3)) : gnt_cfg;
                if (gwait == 0) begin bus.data_gnt_i = 1'b1; gwait = -1; end
                else begin bus.data_gnt_i = 1'b0; gwait--; end
            end else begin
                bus.data_gnt_i = spur && ($urandom_range(0, 7) == 0);
                gwait = -1;
            end
            if (outst) begin
                if (rwait == 0) begin
                    bus.data_rvalid_i = 1'b1;
                    bus.data_rdata_i  = rfix_en ? rfix : $urandom;
                end else begin
                    bus.data_rvalid_i = 1'b0;
                    rwait--;
                end
            end else begin
                bus.data_rvalid_i = spur && ($urandom_range(0, 7) == 0);
                bus.data_rdata_i  = $urandom;
            end
        end
    end

    task automatic do_op(input bit we, input logic [1:0] sz, input bit sx, input logic [31:0] a,
                         input logic [31:0] wd, input logic [4:0] rd, output int waited);
        bit acc;
        acc = 0; waited = 0;
        bus.req_valid_i = 1'b1; bus.we_i = we; bus.size_i = sz; bus.sign_ext_i = sx;
        bus.addr_i = a; bus.wdata_i = wd; bus.rd_i = rd;
        while (!acc && waited < 50) begin
            @(negedge clk);
            acc = bus.req_ready_o;
            @(posedge clk); #1;
            waited++;
        end
        bus.req_valid_i = 1'b0;
        if (!acc) chk("accept_timeout", acc, 1);
    endtask

    task automatic directed_load(input logic [31:0] a, input logic [1:0] sz, input bit sx,
                                 input logic [4:0] rd, input logic [3:0] be, input logic [31:0] exp);
        int n;
        do_op(1'b0, sz, sx, a, 32'h0, rd, n);
        @(negedge clk);
        chk("dir_data_req", bus.data_req_o, 1);
        chk("dir_data_addr", bus.data_addr_o, a & ~32'h3);
        chk("dir_data_be", bus.data_be_o, be);
        @(negedge clk);
        chk("dir_wb_early", bus.wb_valid_o, 0);
        @(negedge clk);
        chk("dir_wb_valid", bus.wb_valid_o, 1);
        chk("dir_wb_data", bus.wb_data_o, exp);
        chk("dir_wb_rd", bus.wb_rd_o, rd);
        chk("dir_ready_back", bus.req_ready_o, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, vectors=%0d", vectors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          n, sr, idle;
        logic [1:0]  sz;
        logic [31:0] a;
        rst = 1'b1;
        bus.req_valid_i = 1'b0; bus.we_i = 1'b0; bus.size_i = 2'b00; bus.sign_ext_i = 1'b0;
        bus.addr_i = 32'h0; bus.wdata_i = 32'h0; bus.rd_i = 5'd0;
        @(posedge clk); #1;
        model_on = 1'b1;
        @(negedge clk);
        chk("reset_ready", bus.req_ready_o, 1);
        chk("reset_data_req", bus.data_req_o, 0);
        chk("reset_wb_valid", bus.wb_valid_o, 0);
        chk("reset_err", bus.err_o, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Word load, immediate grant and response.
        gnt_cfg = 0; rv_cfg = 0; rfix_en = 1'b1; rfix = 32'hDEAD_BEEF;
        directed_load(32'h100, 2'd2, 1'b0, 5'd5, 4'b1111, 32'hDEAD_BEEF);

        // Top-byte load, signed then unsigned.
        rfix = 32'h80FF_FF00;
        directed_load(32'h103, 2'd0, 1'b1, 5'd7, 4'b1000, 32'hFFFF_FF80);
        directed_load(32'h103, 2'd0, 1'b0, 5'd8, 4'b1000, 32'h0000_0080);

        // Upper-half store with grant held off three cycles.
        gnt_cfg = 3;
        do_op(1'b1, 2'd1, 1'b0, 32'h202, 32'h1234_ABCD, 5'd2, n);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("st_data_req", bus.data_req_o, 1);
            chk("st_data_addr", bus.data_addr_o, 32'h200);
            chk("st_data_be", bus.data_be_o, 4'b1100);
            chk("st_data_wdata", bus.data_wdata_o, 32'hABCD_ABCD);
            chk("st_data_we", bus.data_we_o, 1);
        end
        @(negedge clk);
        chk("st_req_drop", bus.data_req_o, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("st_no_wb", bus.wb_valid_o, 0);
        end
        @(posedge clk); #1;

        // Misaligned word, then illegal size.
        gnt_cfg = 0;
        do_op(1'b0, 2'd2, 1'b0, 32'h101, 32'h0, 5'd4, n);
        @(negedge clk);
        chk("mis_err", bus.err_o, 1);
        chk("mis_data_req", bus.data_req_o, 0);
        chk("mis_ready", bus.req_ready_o, 1);
        @(negedge clk);
        chk("mis_err_pulse", bus.err_o, 0);
        chk("mis_data_req2", bus.data_req_o, 0);
        @(posedge clk); #1;
        do_op(1'b0, 2'd3, 1'b0, 32'h0, 32'h0, 5'd4, n);
        @(negedge clk);
        chk("ill_err", bus.err_o, 1);
        chk("ill_data_req", bus.data_req_o, 0);
        chk("ill_ready", bus.req_ready_o, 1);
        @(negedge clk);
        chk("ill_err_pulse", bus.err_o, 0);
        @(posedge clk); #1;

        // Reset while waiting for the response; the late response is dropped.
        gnt_cfg = 0; rv_cfg = 3; rfix = 32'h5555_AAAA;
        do_op(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 5'd6, n);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("wrst_ready", bus.req_ready_o, 1);
        chk("wrst_data_req", bus.data_req_o, 0);
        chk("wrst_data_we", bus.data_we_o, 0);
        chk("wrst_data_be", bus.data_be_o, 0);
        chk("wrst_data_addr", bus.data_addr_o, 0);
        chk("wrst_data_wdata", bus.data_wdata_o, 0);
        chk("wrst_wb_valid", bus.wb_valid_o, 0);
        chk("wrst_wb_rd", bus.wb_rd_o, 0);
        chk("wrst_wb_data", bus.wb_data_o, 0);
        chk("wrst_err", bus.err_o, 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("wrst_no_wb", bus.wb_valid_o, 0);
            chk("wrst_idle", bus.req_ready_o, 1);
        end
        @(posedge clk); #1;

        // Back-to-back loads with request held.
        rv_cfg = 0; rfix = 32'h0BAD_F00D;
        do_op(1'b0, 2'd2, 1'b0, 32'h300, 32'h0, 5'd3, n);
        do_op(1'b0, 2'd2, 1'b0, 32'h304, 32'h0, 5'd9, n);
        chk("b2b_accept_cycles", n, 3);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("b2b_wb_valid", bus.wb_valid_o, 1);
        chk("b2b_wb_rd", bus.wb_rd_o, 9);
        chk("b2b_wb_data", bus.wb_data_o, 32'h0BAD_F00D);
        @(posedge clk); #1;

        // Randomized traffic with random bus timing, spurious handshakes and resets.
        gnt_cfg = -1; rv_cfg = -1; rfix_en = 1'b0; spur = 1'b1;
        for (int i = 0; i < 300; i++) begin
            idle = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
            for (int k = 0; k < idle; k++) begin
                rst = ($urandom_range(0, 24) == 0);
                @(posedge clk); #1;
            end
            rst = 1'b0;
            sr = int'($urandom_range(0, 9));
            sz = (sr < 3) ? 2'd0 : (sr < 6) ? 2'd1 : (sr < 9) ? 2'd2 : 2'd3;
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) a[0] = 1'b0;
                else if (sz == 2'd2) a[1:0] = 2'b00;
            end
            do_op(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom,
                  5'($urandom_range(0, 31)), n);
        end
        spur = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter DATA_WIDTH, default 32 (package value), SHALL set the width of address, write-data and read-data paths.
REQ-002 clk_i  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_i  input  1  SHALL be the reset: synchronous, active-high.
REQ-004 req_valid_i  input  1  SHALL mark a valid memory op from execute.
REQ-005 req_ready_o  output  1  SHALL mark that the LSU accepts an op this cycle.
REQ-006 we_i  input  1  SHALL select store (1) or load (0).
REQ-007 size_i  input  2  SHALL encode access size: 00 byte, 01 half, 10 word, 11 illegal.
REQ-008 sign_ext_i  input  1  SHALL select sign (1) or zero (0) extension for loads.
REQ-009 addr_i  input  DATA_WIDTH  SHALL carry the byte address (ALU result).
REQ-010 wdata_i  input  DATA_WIDTH  SHALL carry store data, right-aligned.
REQ-011 rd_i  input  5  SHALL carry the load destination register.
REQ-012 data_req_o / data_gnt_i  output / input  1 / 1  SHALL form the memory request handshake.
REQ-013 data_addr_o  output  DATA_WIDTH  SHALL carry the word-aligned address (bits [1:0] = 0).
REQ-014 data_we_o, data_be_o, data_wdata_o  output  1, 4, DATA_WIDTH  SHALL carry write enable, byte enables, lane-placed write data.
REQ-015 data_rvalid_i / data_rdata_i  input  1 / DATA_WIDTH  SHALL carry the response; asserted for loads and stores.
REQ-016 wb_valid_o, wb_rd_o, wb_data_o  output  1, 5, DATA_WIDTH  SHALL carry the load result to writeback.
REQ-017 err_o  output  1  SHALL pulse for a misaligned or illegal-size op.

Function
REQ-018 FSM states SHALL be IDLE, REQ, WAIT; req_ready_o = 1 only in IDLE.
REQ-019 Accept (req_valid_i & req_ready_o) SHALL register we, size, sign_ext, addr, wdata, rd.
REQ-020 Misaligned SHALL be: half with addr[0]=1; word with addr[1:0]!=0; size 11 always illegal.
REQ-021 Erroneous accepted op SHALL remain in IDLE, issue no memory request, pulse err_o for 1 cycle the next cycle.
REQ-022 Valid accepted op SHALL enter REQ next cycle; data_req_o = 1 throughout REQ; data_addr_o/we/be/wdata held stable until grant.
REQ-023 REQ -> WAIT SHALL occur on data_gnt_i = 1 in REQ; data_req_o deasserted from that next cycle.
REQ-024 WAIT -> IDLE SHALL occur on data_rvalid_i = 1; data_rvalid_i ignored in IDLE and REQ.
REQ-025 Byte enables SHALL be 4'b0001<<addr[1:0] (byte), 4'b0011<<addr[1:0] (half), 4'b1111 (word).
REQ-026 Store data SHALL be replicated: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata.
REQ-027 Load data SHALL be data_rdata_i >> (8*addr[1:0]), truncated to size, then sign/zero extended per sign_ext.
REQ-028 For loads, wb_valid_o SHALL pulse 1 cycle, the cycle after data_rvalid_i, with registered wb_data_o and wb_rd_o; stores SHALL never assert wb_valid_o.
REQ-029 Minimum latency: accept c0, req+gnt c1, rvalid c2, wb_valid_o and req_ready_o c3.
REQ-030 wb_data_o and wb_rd_o SHALL hold their last value when wb_valid_o = 0.

Reset
REQ-031 With rst_i = 1, next edge SHALL set: state IDLE, req_ready_o 1, data_req_o 0, data_we_o 0, data_be_o 0, data_addr_o 0, data_wdata_o 0, wb_valid_o 0, wb_rd_o 0, wb_data_o 0, err_o 0.
REQ-032 Reset in REQ or WAIT SHALL abandon the op; no wb_valid_o or err_o results; a later data_rvalid_i SHALL be ignored.

Verification
REQ-033 Word load addr 0x100, gnt same cycle as req, rvalid next cycle with 0xDEADBEEF -> data_addr_o 0x100, be 1111, wb_valid_o one cycle later, wb_data_o 0xDEADBEEF, wb_rd_o = rd_i.
REQ-034 Signed byte load addr 0x103, rdata 0x80FF_FF00 -> be 1000, wb_data_o 0xFFFFFF80; unsigned -> 0x00000080.
REQ-035 Half store addr 0x202, wdata 0x1234ABCD, gnt delayed 3 cycles -> data_req_o high 4 cycles, addr 0x200, be 1100, wdata 0xABCDABCD stable, no wb_valid_o.
REQ-036 Word load addr 0x101; then size 11 at 0x0 -> each: err_o 1-cycle pulse, data_req_o stays 0, req_ready_o stays 1.
REQ-037 rst_i asserted in WAIT, then rvalid -> state IDLE, no wb_valid_o, all outputs at reset values.
REQ-038 Back-to-back loads with req_valid_i held -> second accepted only in cycle wb_valid_o of first; each rd_i returned in order.
